// File: rtl/seq_mult_ctrl.sv
// Sequential shift-and-add unsigned multiplier with start/busy/done handshake.
// One adder is reused for WIDTH iterations; product is registered and only updated on entry to DONE.
module seq_mult_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   mcand;
    logic [PW-1:0]   acc_add;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            nonzero;
    logic            last;

    always_comb begin
        accept  = start && ((state == IDLE) || (state == DONE));
        nonzero = (a != '0) && (b != '0);
        last    = (cnt == LAST);
        // Sum including this iteration's partial product; also the value written on the final iteration.
        acc_add = mplier[0] ? (acc + mcand) : acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nxt = nonzero ? CALC : DONE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CALC: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (nonzero) begin
                            mcand  <= PW'(a);
                            mplier <= b;
                            acc    <= '0;
                            cnt    <= '0;
                        end else begin
                            product <= '0;
                        end
                    end
                end
                CALC: begin
                    acc    <= acc_add;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        product <= acc_add;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed self-checking bench for seq_mult_ctrl at WIDTH=4 and WIDTH=8.
module tb_seq_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        busy;
    logic        done;
    logic [7:0]  product;

    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [15:0] product8;

    int unsigned pass_cnt = 0;
    int unsigned chk_cnt  = 0;

    always #5 clk = ~clk;

    seq_mult_ctrl #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product)
    );

    seq_mult_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .product(product8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; sample/drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for done on the 4-bit DUT; returns edges counted since the call.
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!done && cyc < 40);
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [3:0] x, input logic [3:0] y,
                          input int exp_prod, input int exp_lat);
        int cyc;
        start = 1'b1; a = x; b = y;
        tick();
        start = 1'b0;
        cyc = 1;
        if (!done) begin
            int more;
            wait_done(more);
            cyc += more;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_prod"}, 32'(product), 32'(exp_prod));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int dones;
        int ovl;
        int tot;
        logic [3:0] na;
        logic [3:0] nb;

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_prod", 32'(product), 32'd0);
        check("rst_prod8", 32'(product8), 32'd0);
        rst = 1'b0;
        tick();

        // 15*15: busy for 4 cycles, done in the 5th
        start = 1'b1; a = 4'd15; b = 4'd15;
        tick();
        start = 1'b0; a = 4'd3; b = 4'd1;
        for (int i = 0; i < 4; i++) begin
            check("ff_busy", 32'(busy), 32'd1);
            check("ff_nodone", 32'(done), 32'd0);
            check("ff_no_partial", 32'(product), 32'd0);
            tick();
        end
        check("ff_done", 32'(done), 32'd1);
        check("ff_prod", 32'(product), 32'd225);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("ff_hold", 32'(product), 32'd225);
            check("ff_idle", 32'(busy | done), 32'd0);
        end

        // zero fast path
        run_op("zero_a", 4'd0, 4'd9, 0, 1);
        tick();
        check("zero_idle", 32'(done), 32'd0);
        run_op("zero_b", 4'd7, 4'd0, 0, 1);
        tick();

        // start while busy is ignored
        start = 1'b1; a = 4'd3; b = 4'd5;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; a = 4'd9; b = 4'd9;
        tick();
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                dones++;
                check("busy_ign_prod", 32'(product), 32'd15);
            end
            tick();
        end
        check("busy_ign_dones", 32'(dones), 32'd1);

        // back-to-back: 6*7 then 11*13 accepted in the DONE cycle
        start = 1'b1; a = 4'd6; b = 4'd7;
        wait_done(cyc);
        check("b2b_lat1", 32'(cyc), 32'd5);
        check("b2b_prod1", 32'(product), 32'd42);
        a = 4'd11; b = 4'd13;
        tick();
        start = 1'b0;
        check("b2b_no_idle", 32'(busy), 32'd1);
        wait_done(cyc);
        check("b2b_lat2", 32'(cyc), 32'd4);
        check("b2b_prod2", 32'(product), 32'd143);
        tick();

        // reset during the 2nd CALC cycle
        start = 1'b1; a = 4'd12; b = 4'd10;
        tick();
        start = 1'b0;
        tick();
        check("rmid_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rmid_busy", 32'(busy), 32'd0);
        check("rmid_done", 32'(done), 32'd0);
        check("rmid_prod", 32'(product), 32'd0);
        tick();
        check("rmid_stay_idle", 32'(busy | done), 32'd0);
        run_op("after_rst", 4'd2, 4'd3, 6, 5);
        tick();

        // exhaustive back-to-back stream
        dones = 0; ovl = 0; tot = 0;
        start = 1'b1; a = 4'd0; b = 4'd0;
        for (int i = 0; i < 256; i++) begin
            na = 4'(i >> 4);
            nb = 4'(i);
            cyc = 0;
            do begin
                tick();
                cyc++;
                if (busy && done) ovl++;
            end while (!done && cyc < 40);
            tot += cyc;
            if (done) dones++;
            check("exh_prod", 32'(product), 32'(int'(na) * int'(nb)));
            a = 4'((i + 1) >> 4);
            b = 4'(i + 1);
        end
        start = 1'b0;
        check("exh_dones", 32'(dones), 32'd256);
        check("exh_cycles", 32'(tot), 32'd1156);
        check("exh_overlap", 32'(ovl), 32'd0);
        tick();

        // WIDTH=8 scaling
        start8 = 1'b1; a8 = 8'd255; b8 = 8'd255;
        tick();
        start8 = 1'b0;
        cyc = 1;
        while (!done8 && cyc < 40) begin
            check("w8_busy", 32'(busy8), 32'd1);
            tick();
            cyc++;
        end
        check("w8_lat", 32'(cyc), 32'd9);
        check("w8_prod", 32'(product8), 32'd65025);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
